// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter: local-op FSM states and the bus op record.
package reg_bus_pkg;

  localparam int DWIDTH = 32;
  localparam int ALINES = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    L_BUS = 2'd1,
    L_ACK = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic              we;
    logic              rd;
    logic [ALINES-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } reg_op_t;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Bundle of the SPI (S), local (L) and bank (M) sides of the register-bus arbiter.
interface reg_bus_arbiter_if #(
    parameter int DWIDTH = reg_bus_pkg::DWIDTH,
    parameter int ALINES = reg_bus_pkg::ALINES
);
    logic              s_wr;
    logic              s_rd;
    logic [ALINES-1:0] s_addr;
    logic [DWIDTH-1:0] s_wdata;
    logic [DWIDTH-1:0] s_rdata;
    logic              s_err;

    logic              l_req;
    logic              l_we;
    logic [ALINES-1:0] l_addr;
    logic [DWIDTH-1:0] l_wdata;
    logic              l_ack;
    logic [DWIDTH-1:0] l_rdata;

    logic              m_wr;
    logic              m_rd;
    logic [ALINES-1:0] m_addr;
    logic [DWIDTH-1:0] m_wdata;
    logic [DWIDTH-1:0] m_rdata;

    // Arbiter side
    modport slave (
        input  s_wr, s_rd, s_addr, s_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
        output s_rdata, s_err, l_ack, l_rdata, m_wr, m_rd, m_addr, m_wdata
    );

    // Environment side: SPI slave, local master and register bank together
    modport master (
        output s_wr, s_rd, s_addr, s_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  s_rdata, s_err, l_ack, l_rdata, m_wr, m_rd, m_addr, m_wdata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Shares the register bank port between the SPI slave (fixed priority, never stalled)
// and a req/ack local master served only in bus cycles the SPI side leaves idle.
module reg_bus_arbiter #(
    parameter int DWIDTH = reg_bus_pkg::DWIDTH,
    parameter int ALINES = reg_bus_pkg::ALINES
) (
    input  logic                clk,
    input  logic                rst,
    reg_bus_arbiter_if.slave    bus
);
    import reg_bus_pkg::reg_op_t;
    import reg_bus_pkg::fsm_state_e;
    import reg_bus_pkg::IDLE;
    import reg_bus_pkg::L_BUS;
    import reg_bus_pkg::L_ACK;

    fsm_state_e state;
    reg_op_t    nxt_op;
    logic       load;
    logic       s_stb;
    logic       s_rd_pend;
    logic       l_rd_pend;

    assign s_stb = bus.s_wr | bus.s_rd;

    // A simultaneous wr+rd strobe is a write; the read half is dropped.
    always_comb begin
        load   = 1'b0;
        nxt_op = '0;
        if (s_stb) begin
            load         = 1'b1;
            nxt_op.we    = bus.s_wr;
            nxt_op.rd    = bus.s_rd & ~bus.s_wr;
            nxt_op.addr  = bus.s_addr;
            nxt_op.wdata = bus.s_wdata;
        end else if (state == IDLE && bus.l_req) begin
            load         = 1'b1;
            nxt_op.we    = bus.l_we;
            nxt_op.rd    = ~bus.l_we;
            nxt_op.addr  = bus.l_addr;
            nxt_op.wdata = bus.l_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_wr    <= 1'b0;
            bus.m_rd    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.s_err   <= 1'b0;
            bus.s_rdata <= '0;
            s_rd_pend   <= 1'b0;
        end else begin
            bus.m_wr  <= load & nxt_op.we;
            bus.m_rd  <= load & nxt_op.rd;
            bus.s_err <= bus.s_wr & bus.s_rd;
            if (load) begin
                bus.m_addr  <= nxt_op.addr;
                bus.m_wdata <= nxt_op.wdata;
            end
            // SPI read data is captured at the end of the bus cycle that carried it
            s_rd_pend <= s_stb & nxt_op.rd;
            if (s_rd_pend)
                bus.s_rdata <= bus.m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.l_ack   <= 1'b0;
            bus.l_rdata <= '0;
            l_rd_pend   <= 1'b0;
        end else begin
            bus.l_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.l_req && !s_stb) begin
                        state     <= L_BUS;
                        l_rd_pend <= ~bus.l_we;
                    end
                end
                L_BUS: begin
                    if (l_rd_pend)
                        bus.l_rdata <= bus.m_rdata;
                    bus.l_ack <= 1'b1;
                    state     <= L_ACK;
                end
                // l_req is ignored here so a late deassert cannot relaunch the op
                L_ACK:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomized bench for reg_bus_arbiter against a bus-transaction reference model.
module tb_reg_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.DWIDTH(32), .ALINES(7)) bif ();

    reg_bus_arbiter #(.DWIDTH(32), .ALINES(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Register bank: combinational read, written when the bus carries a write
    logic [31:0] bank [128];
    assign bif.m_rdata = bank[bif.m_addr];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: expected bus content of the current cycle and visible results
    logic [31:0] mmem [128];
    logic        cur_wr, cur_rd, cur_loc;
    logic [6:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic        e_l_ack, e_s_err;
    logic [31:0] e_l_rdata, e_s_rdata;

    // Random local master state
    logic        lm_req, lm_we, lm_drop_next;
    logic [6:0]  lm_addr;
    logic [31:0] lm_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        cur_wr = 0; cur_rd = 0; cur_loc = 0; cur_addr = '0; cur_wdata = '0;
        e_l_ack = 0; e_s_err = 0; e_l_rdata = '0; e_s_rdata = '0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_m_wr"},    32'(bif.m_wr),    32'(cur_wr));
        chk({pfx, "_m_rd"},    32'(bif.m_rd),    32'(cur_rd));
        chk({pfx, "_m_addr"},  32'(bif.m_addr),  32'(cur_addr));
        chk({pfx, "_m_wdata"}, bif.m_wdata,      cur_wdata);
        chk({pfx, "_l_ack"},   32'(bif.l_ack),   32'(e_l_ack));
        chk({pfx, "_l_rdata"}, bif.l_rdata,      e_l_rdata);
        chk({pfx, "_s_rdata"}, bif.s_rdata,      e_s_rdata);
        chk({pfx, "_s_err"},   32'(bif.s_err),   32'(e_s_err));
    endtask

    // Called at a negedge: drive inputs, advance the model over one edge, check at the next negedge.
    task automatic step(input logic swr, input logic srd, input logic [6:0] saddr,
                        input logic [31:0] swdata, input logic lreq, input logic lwe,
                        input logic [6:0] laddr, input logic [31:0] lwdata);
        logic free, n_ack;
        bif.s_wr = swr; bif.s_rd = srd; bif.s_addr = saddr; bif.s_wdata = swdata;
        bif.l_req = lreq; bif.l_we = lwe; bif.l_addr = laddr; bif.l_wdata = lwdata;

        // Results of the op the bus carries this cycle
        n_ack = cur_loc;
        if (cur_loc && cur_rd)  e_l_rdata = mmem[cur_addr];
        if (!cur_loc && cur_rd) e_s_rdata = mmem[cur_addr];
        if (cur_wr)             mmem[cur_addr] = cur_wdata;
        // Local ops may not issue while one is on the bus or being acknowledged
        free    = !cur_loc && !e_l_ack;
        e_l_ack = n_ack;
        e_s_err = swr & srd;
        if (swr | srd) begin
            cur_wr = swr; cur_rd = srd & ~swr; cur_addr = saddr; cur_wdata = swdata; cur_loc = 0;
        end else if (free && lreq) begin
            cur_wr = lwe; cur_rd = ~lwe; cur_addr = laddr; cur_wdata = lwdata; cur_loc = 1;
        end else begin
            cur_wr = 0; cur_rd = 0; cur_loc = 0;
        end

        @(posedge clk);
        @(negedge clk);
        check_outputs("cyc");
        if (bif.m_wr) bank[bif.m_addr] = bif.m_wdata;
    endtask

    task automatic idle_step();
        step(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
    endtask

    task automatic rand_step();
        int r;
        logic swr, srd;
        if (lm_drop_next) begin
            lm_req = 0; lm_drop_next = 0;
        end else if (lm_req && e_l_ack) begin
            if ($urandom % 3 == 0) lm_drop_next = 1;
            else lm_req = 0;
        end else if (lm_req && ($urandom % 24 == 0)) begin
            lm_req = 0;
        end else if (!lm_req && ($urandom % 3 == 0)) begin
            lm_req = 1; lm_we = 1'($urandom);
            lm_addr = 7'($urandom_range(0, 15)); lm_wdata = $urandom;
        end
        r = int'($urandom % 16);
        swr = (r < 3) || (r == 6);
        srd = (r >= 3 && r < 7);
        step(swr, srd, 7'($urandom_range(0, 15)), $urandom, lm_req, lm_we, lm_addr, lm_wdata);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            bank[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            mmem[i] = bank[i];
        end
        bank[7'h12] = 32'h0000_CAFE; mmem[7'h12] = 32'h0000_CAFE;
        bank[7'h21] = 32'h2121_F00D; mmem[7'h21] = 32'h2121_F00D;
        bif.s_wr = 0; bif.s_rd = 0; bif.s_addr = '0; bif.s_wdata = '0;
        bif.l_req = 0; bif.l_we = 0; bif.l_addr = '0; bif.l_wdata = '0;
        lm_req = 0; lm_we = 0; lm_addr = '0; lm_wdata = '0; lm_drop_next = 0;
        model_reset();

        @(negedge clk);
        check_outputs("rst");
        rst = 0;

        // SPI write, local idle
        step(1, 0, 7'h05, 32'hDEAD_BEEF, 0, 0, 7'h0, 32'h0);
        chk("spiwr_m_wr", 32'(bif.m_wr), 1);
        chk("spiwr_m_addr", 32'(bif.m_addr), 32'h05);
        chk("spiwr_m_wdata", bif.m_wdata, 32'hDEAD_BEEF);
        chk("spiwr_l_ack", 32'(bif.l_ack), 0);
        idle_step();

        // SPI read: strobe at T, m_rd at T+1, data from T+2 and held
        step(0, 1, 7'h12, 32'h0, 0, 0, 7'h0, 32'h0);
        chk("spird_m_rd", 32'(bif.m_rd), 1);
        idle_step();
        chk("spird_data", bif.s_rdata, 32'h0000_CAFE);
        idle_step();
        chk("spird_held", bif.s_rdata, 32'h0000_CAFE);

        // Local write with l_req still high during the ack cycle
        step(0, 0, 7'h0, 32'h0, 1, 1, 7'h20, 32'h1234);
        chk("lwr_m_wr", 32'(bif.m_wr), 1);
        chk("lwr_m_addr", 32'(bif.m_addr), 32'h20);
        step(0, 0, 7'h0, 32'h0, 1, 1, 7'h20, 32'h1234);
        chk("lwr_ack", 32'(bif.l_ack), 1);
        step(0, 0, 7'h0, 32'h0, 1, 1, 7'h20, 32'h1234);
        chk("lwr_no_relaunch", 32'(bif.m_wr), 0);
        chk("lwr_ack_once", 32'(bif.l_ack), 0);
        idle_step();
        chk("lwr_bank", bank[7'h20], 32'h1234);

        // l_req read and s_wr in the same cycle: SPI first, local next
        step(1, 0, 7'h03, 32'h0303_0303, 1, 0, 7'h21, 32'h0);
        chk("coll_spi_first", 32'(bif.m_addr), 32'h03);
        step(0, 0, 7'h0, 32'h0, 1, 0, 7'h21, 32'h0);
        chk("coll_loc_rd", 32'(bif.m_rd), 1);
        chk("coll_loc_addr", 32'(bif.m_addr), 32'h21);
        step(0, 0, 7'h0, 32'h0, 1, 0, 7'h21, 32'h0);
        chk("coll_ack", 32'(bif.l_ack), 1);
        chk("coll_l_rdata", bif.l_rdata, 32'h2121_F00D);
        idle_step();

        // SPI read strobe during L_BUS of a local write
        step(0, 0, 7'h0, 32'h0, 1, 1, 7'h30, 32'hA5A5_0030);
        step(0, 1, 7'h12, 32'h0, 1, 1, 7'h30, 32'hA5A5_0030);
        chk("mid_ack", 32'(bif.l_ack), 1);
        chk("mid_spi_addr", 32'(bif.m_addr), 32'h12);
        step(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        chk("mid_s_rdata", bif.s_rdata, 32'h0000_CAFE);
        chk("mid_bank", bank[7'h30], 32'hA5A5_0030);

        // Write and read strobes together
        step(1, 1, 7'h12, 32'h0000_0055, 0, 0, 7'h0, 32'h0);
        chk("both_err", 32'(bif.s_err), 1);
        chk("both_m_wr", 32'(bif.m_wr), 1);
        chk("both_m_rd", 32'(bif.m_rd), 0);
        idle_step();
        chk("both_rdata_kept", bif.s_rdata, 32'h0000_CAFE);
        chk("both_err_pulse", 32'(bif.s_err), 0);

        for (int i = 0; i < 3000; i++) rand_step();
        lm_req = 0; lm_drop_next = 0;
        for (int i = 0; i < 3; i++) idle_step();

        // Asynchronous reset while a local read is on the bus
        step(0, 0, 7'h0, 32'h0, 1, 0, 7'h21, 32'h0);
        chk("arst_pre_rd", 32'(bif.m_rd), 1);
        bif.l_req = 0;
        #1 rst = 1;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            chk("arst_no_ack", 32'(bif.l_ack), 0);
        end

        for (int i = 0; i < 500; i++) rand_step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single register bank port (wr/addr/din/dout) between two masters: the SPI slave (port S, strobe-based, cannot be stalled) and an on-chip local master (port L, req/ack handshake, e.g. power-up init sequencer or debug UART).
- Sits between slave_spi and register_main inside the register interface.
- Fixed priority: S always wins. L is served in idle bus cycles and is never aborted once issued.

Parameters:
- DWIDTH, 32, register data width.
- ALINES, 7, register address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s_wr  in  1  SPI write strobe, 1-cycle pulse.
- s_rd  in  1  SPI read strobe, 1-cycle pulse.
- s_addr  in  ALINES  SPI address, valid with strobe.
- s_wdata  in  DWIDTH  SPI write data, valid with s_wr.
- s_rdata  out  DWIDTH  SPI read data, registered, held until next SPI read.
- l_req  in  1  local request level, held until l_ack.
- l_we  in  1  local op: 1=write, 0=read; stable while l_req.
- l_addr  in  ALINES  local address; stable while l_req.
- l_wdata  in  DWIDTH  local write data; stable while l_req.
- l_ack  out  1  1-cycle completion pulse.
- l_rdata  out  DWIDTH  local read data, valid with l_ack, held after.
- m_wr  out  1  bank write strobe (registered).
- m_rd  out  1  bank read strobe (registered), for side-effect registers.
- m_addr  out  ALINES  bank address (registered).
- m_wdata  out  DWIDTH  bank write data (registered).
- m_rdata  in  DWIDTH  bank read data, combinational from m_addr.
- s_err  out  1  1-cycle pulse: s_wr and s_rd asserted in the same cycle.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal read-pending flags 0. Reset mid-transaction abandons it: no l_ack is issued and L must re-request.
- Bus registers: each cycle, m_* load exactly one source.
  - Priority 1: SPI strobe.
  - Priority 2: local op when FSM is IDLE and l_req=1.
  - Otherwise m_wr=m_rd=0. m_addr and m_wdata hold their previous values.
- SPI path:
  - s_wr or s_rd at cycle T: at T+1, m_addr=s_addr, m_wr=s_wr, m_rd=s_rd&~s_wr, m_wdata=s_wdata.
  - Read: s_rdata<=m_rdata at the end of T+1, so it is valid from T+2 (latency 2). The SPI slave must sample it no earlier than T+2.
  - s_wr and s_rd together: treated as a write; no read occurs, s_rdata is unchanged, s_err pulses at T+1.
- Local FSM, states IDLE, L_BUS, L_ACK:
  - IDLE -> L_BUS when l_req=1 and there is no SPI strobe this cycle. The m_* registers load the local op on the same edge.
  - IDLE stays IDLE when an SPI strobe is present. L is deferred with no limit; the SPI strobe rate (at most 1 per SPI word) makes starvation impossible.
  - L_BUS: the bus carries the local op for exactly this one cycle. If it is a read, l_rdata<=m_rdata. Next state is L_ACK and l_ack<=1.
  - An SPI strobe during L_BUS is loaded into m_* on the next edge. This does not conflict: the local op completes in L_BUS and is never aborted.
  - L_ACK: l_ack=1 for this cycle only. l_req is ignored in this cycle so a late deassert cannot re-launch. Next state is IDLE unconditionally.
  - Best-case local latency is l_req rise to l_ack = 2 cycles. Throughput is 1 local op per 3 cycles.
- l_req deasserted before l_ack:
  - In IDLE: the request is withdrawn cleanly.
  - In L_BUS: the op still completes and l_ack is still pulsed.
- Back-to-back SPI strobes are each serviced in consecutive bus cycles. s_rdata updates only for read strobes.

Decomposition:
- Package reg_bus_pkg:
  - typedef enum of FSM states: IDLE, L_BUS, L_ACK.
  - typedef struct reg_op_t {we, rd, addr, wdata}, parameterised via the package-level DWIDTH/ALINES defaults.
- No sub-module: FSM plus bus register fit in one module.

Test Plan:
- SPI write 0xDEADBEEF to 0x05, L idle -> m_wr=1, m_addr=0x05, m_wdata=0xDEADBEEF exactly one cycle later; l_ack stays 0.
- SPI read of 0x12 with bank returning 0x0000CAFE -> m_rd pulse at T+1, s_rdata=0x0000CAFE from T+2 and held.
- Local write 0x1234 to 0x20 with no SPI traffic -> m_wr at cycle 1 after l_req, l_ack at cycle 2, no re-launch while l_req is still high during the l_ack cycle.
- l_req (read 0x21) and s_wr (0x03) rise in the same cycle -> SPI op on the bus first, local read on the next cycle, l_ack one cycle later, l_rdata equal to the bank value at 0x21.
- SPI strobe during L_BUS -> local op completes unaltered, SPI op on the bus the following cycle, both results correct.
- s_wr=s_rd=1 -> s_err pulse, write performed, s_rdata unchanged.
- rst asserted during L_BUS -> all outputs 0 immediately (asynchronous), no l_ack after release.
